// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Processor-side initiator for data_memory. It turns byte, half
//               and word loads/stores into word accesses. Sub-word stores are
//               done as read-modify-write. Load lanes are sign/zero-extended.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_write_data_o,
    input  logic [31:0] mem_read_data_i
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        merge_q, merge_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_error_q, resp_error_d;

    logic               req_err;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [31:0]        load_ext;
    logic [31:0]        merged;

    // Upper byte-address bits alias onto the decoded word range.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[31:ADDR_W+2];

    // Illegal size or misaligned access is rejected before any memory traffic.
    always_comb begin
        req_err = (req_size_i == 2'b11)
                | ((req_size_i == 2'b01) & req_addr_i[0])
                | ((req_size_i == 2'b10) & (req_addr_i[1:0] != 2'b00));
    end

    // Extract the addressed lane from the read word and extend it.
    always_comb begin
        lane_b = mem_read_data_i[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_read_data_i[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_ext = mem_read_data_i;
        endcase
    end

    // Replace the target lane of the read word, keeping the other lanes intact.
    always_comb begin
        merged = mem_read_data_i;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Next-state logic and memory strobes, decoded from state only.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        size_d           = size_q;
        signed_d         = signed_q;
        wdata_d          = wdata_q;
        merge_d          = merge_q;
        rdata_d          = 32'd0;
        resp_valid_d     = 1'b0;
        resp_error_d     = 1'b0;
        mem_read_o       = 1'b0;
        mem_write_o      = 1'b0;
        mem_write_data_o = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i[ADDR_W+1:0];
                    size_d   = req_size_i;
                    signed_d = req_signed_i;
                    wdata_d  = req_wdata_i;
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (!req_write_i) begin
                        state_d = LOAD;
                    end else if (req_size_i == 2'b10) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                mem_read_o   = 1'b1;
                rdata_d      = load_ext;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            STORE: begin
                mem_write_o      = 1'b1;
                mem_write_data_o = wdata_q;
                resp_valid_d     = 1'b1;
                state_d          = IDLE;
            end
            RMW_RD: begin
                mem_read_o = 1'b1;
                merge_d    = merged;
                state_d    = RMW_WR;
            end
            RMW_WR: begin
                mem_write_o      = 1'b1;
                mem_write_data_o = merge_q;
                resp_valid_d     = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            wdata_q      <= 32'd0;
            merge_q      <= 32'd0;
            rdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign resp_valid_o  = resp_valid_q;
    assign resp_error_o  = resp_error_q;
    assign resp_rdata_o  = rdata_q;
    assign mem_address_o = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a word memory
//               and a byte-lane reference model of the memory contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    // Results captured by issue()
    int          last_lat, last_nrd, last_nwr;
    logic [31:0] last_rd, last_maddr;
    logic        last_er, last_both, last_extra;

    load_store_unit #(.ADDR_W(10)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_write_i      (req_write),
        .req_size_i       (req_size),
        .req_signed_i     (req_signed),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .resp_valid_o     (resp_valid),
        .resp_rdata_o     (resp_rdata),
        .resp_error_o     (resp_error),
        .mem_write_o      (mem_write),
        .mem_read_o       (mem_read),
        .mem_address_o    (mem_address),
        .mem_write_data_o (mem_write_data),
        .mem_read_data_i  (mem_read_data)
    );

    always #5 clk = ~clk;

    // data_memory stand-in: combinational read, write on rising edge
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address[9:0]];

    // Reference model: byte-lane arithmetic on a word array
    function automatic void ref_op(input logic w, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   output logic [31:0] exp_rd, output logic exp_er,
                                   output int exp_lat);
        int idx, sh, nb;
        logic [31:0] mask, v;
        idx    = int'(a[11:2]);
        sh     = 8 * int'(a[1:0]);
        nb     = 1 << sz;
        exp_rd = 32'd0;
        exp_er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        exp_lat = 1;
        if (exp_er) return;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        if (w) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
            exp_lat = (nb == 4) ? 2 : 3;
        end else begin
            v = (ref_mem[idx] >> sh) & mask;
            if (sg && v[8*nb-1]) v = v | ~mask;
            exp_rd  = v;
            exp_lat = 2;
        end
    endfunction

    task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
    endtask

    // Drive one request (called at a falling edge) and capture its response
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        int guard;
        drive_req(w, sz, sg, a, wd);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        last_lat = 0; last_nrd = 0; last_nwr = 0; last_rd = 32'd0;
        last_er = 1'b0; last_both = 1'b0; last_maddr = 32'd0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_read) last_nrd++;
            if (mem_write) last_nwr++;
            if (mem_read || mem_write) last_maddr = mem_address;
            if (mem_read && mem_write) last_both = 1'b1;
            if (resp_valid) begin
                last_lat = c;
                last_rd  = resp_rdata;
                last_er  = resp_error;
                break;
            end
        end
        @(negedge clk);
        last_extra = resp_valid;
    endtask

    task automatic test_reset();
        tests++;
        if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'd0) begin
            fails++;
            $display("FAIL reset_resp: valid=%b err=%b rdata=%h, required 0/0/0", resp_valid, resp_error, resp_rdata);
        end
        tests++;
        if (req_ready !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: ready=%b rd=%b wr=%b, required 1/0/0", req_ready, mem_read, mem_write);
        end
    endtask

    task automatic test_prefill();
        logic [31:0] erd, d;
        logic eer;
        int elat;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            ref_op(1'b1, 2'd2, 1'b0, 32'(i * 4), d, erd, eer, elat);
            issue(1'b1, 2'd2, 1'b0, 32'(i * 4), d);
            tests++;
            if (last_lat !== elat || last_er !== 1'b0 || mem[i] !== d) begin
                fails++;
                $display("FAIL prefill[%0d]: lat=%0d err=%b mem=%h, required %0d/0/%h", i, last_lat, last_er, mem[i], elat, d);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] erd;
        logic eer;
        int elat;
        ref_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, erd, eer, elat);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        tests++;
        if (last_lat !== 2 || last_maddr !== 32'd4 || last_nwr !== 1 || last_nrd !== 0) begin
            fails++;
            $display("FAIL word_store: lat=%0d addr=%0d wr=%0d rd=%0d, required 2/4/1/0", last_lat, last_maddr, last_nwr, last_nrd);
        end
        ref_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, erd, eer, elat);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        tests++;
        if (last_rd !== 32'hDEADBEEF || last_lat !== 2 || last_maddr !== 32'd4 || last_nrd !== 1) begin
            fails++;
            $display("FAIL word_load: rdata=%h lat=%0d addr=%0d rd=%0d, required DEADBEEF/2/4/1", last_rd, last_lat, last_maddr, last_nrd);
        end
    endtask

    task automatic test_byte_rmw();
        logic [31:0] erd;
        logic eer;
        int elat;
        ref_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, erd, eer, elat);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
        ref_op(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, erd, eer, elat);
        issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA);
        tests++;
        if (mem[4] !== 32'h11AA3344) begin
            fails++;
            $display("FAIL byte_rmw_data: mem4=%h, required 11AA3344", mem[4]);
        end
        tests++;
        if (last_lat !== 3 || last_nrd !== 1 || last_nwr !== 1 || last_both !== 1'b0) begin
            fails++;
            $display("FAIL byte_rmw_seq: lat=%0d rd=%0d wr=%0d both=%b, required 3/1/1/0", last_lat, last_nrd, last_nwr, last_both);
        end
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz  [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
        logic        sg  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ad  [8] = '{32'h12, 32'h12, 32'h10, 32'h12, 32'h12, 32'h11, 32'h13, 32'h10};
        logic [31:0] ex  [8] = '{32'hFFFFFFFF, 32'h000000FF, 32'h00000001, 32'hFFFF80FF,
                                 32'h000080FF, 32'h0000007F, 32'hFFFFFF80, 32'h00007F01};
        logic [31:0] erd;
        logic eer;
        int elat;
        ref_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, erd, eer, elat);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01);
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, sz[i], sg[i], ad[i], 32'hFFFFFFFF);
            tests++;
            if (last_rd !== ex[i] || last_lat !== 2 || last_er !== 1'b0) begin
                fails++;
                $display("FAIL load_ext[%0d]: rdata=%h lat=%0d err=%b, required %h/2/0", i, last_rd, last_lat, last_er, ex[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic        w  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        logic [31:0] ad [4] = '{32'h11, 32'h12, 32'h10, 32'h10};
        for (int i = 0; i < 4; i++) begin
            issue(w[i], sz[i], 1'b0, ad[i], 32'h12345678);
            tests++;
            if (last_er !== 1'b1 || last_lat !== 1 || last_nrd !== 0 || last_nwr !== 0 || last_rd !== 32'd0) begin
                fails++;
                $display("FAIL error[%0d]: err=%b lat=%0d rd=%0d wr=%0d rdata=%h, required 1/1/0/0/0",
                         i, last_er, last_lat, last_nrd, last_nwr, last_rd);
            end
        end
        tests++;
        if (mem[4] !== 32'h80FF7F01) begin
            fails++;
            $display("FAIL error_nowrite: mem4=%h, required 80FF7F01", mem[4]);
        end
    endtask

    task automatic test_random();
        logic        w, sg, eer;
        logic [1:0]  sz;
        logic [31:0] a, d, erd;
        int          elat;
        for (int i = 0; i < 40; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            d  = $urandom;
            ref_op(w, sz, sg, a, d, erd, eer, elat);
            issue(w, sz, sg, a, d);
            tests++;
            if (last_rd !== erd || last_er !== eer || last_lat !== elat) begin
                fails++;
                $display("FAIL random[%0d] w=%b sz=%0d a=%h: rdata=%h err=%b lat=%0d, required %h/%b/%0d",
                         i, w, sz, a, last_rd, last_er, last_lat, erd, eer, elat);
            end
            tests++;
            if (last_both !== 1'b0 || last_extra !== 1'b0) begin
                fails++;
                $display("FAIL random_ctrl[%0d]: rd_wr_overlap=%b resp_stuck=%b, required 0/0", i, last_both, last_extra);
            end
        end
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (mem[k] !== ref_mem[k]) begin
                fails++;
                $display("FAIL random_mem[%0d]: mem=%h, required %h", k, mem[k], ref_mem[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        rw  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]  rs  [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
        logic        rsg [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ra  [4] = '{32'h18, 32'h19, 32'h18, 32'h1C};
        logic [31:0] rwd [4];
        logic [31:0] erd;
        logic        eer;
        int          elat, lat;
        for (int i = 0; i < 4; i++) rwd[i] = $urandom;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_start: ready=%b, required 1", req_ready);
        end
        drive_req(rw[0], rs[0], rsg[0], ra[0], rwd[0]);
        @(posedge clk);
        #1 drive_req(rw[1], rs[1], rsg[1], ra[1], rwd[1]);
        for (int i = 0; i < 4; i++) begin
            ref_op(rw[i], rs[i], rsg[i], ra[i], rwd[i], erd, eer, elat);
            lat = 0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (resp_valid) begin
                    lat = c;
                    break;
                end
            end
            tests++;
            if (lat !== elat || resp_rdata !== erd || resp_error !== eer) begin
                fails++;
                $display("FAIL b2b[%0d]: lat=%0d rdata=%h err=%b, required %0d/%h/%b", i, lat, resp_rdata, resp_error, elat, erd, eer);
            end
            if (i < 3) begin
                tests++;
                if (req_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_accept[%0d]: ready=%b during resp_valid, required 1", i, req_ready);
                end
                @(posedge clk);
                #1;
                if (i + 2 < 4) drive_req(rw[i+2], rs[i+2], rsg[i+2], ra[i+2], rwd[i+2]);
                else req_valid = 1'b0;
            end
        end
        @(negedge clk);
        tests++;
        if (mem[6] !== ref_mem[6] || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_mem: mem6=%h resp_valid=%b, required %h/0", mem[6], resp_valid, ref_mem[6]);
        end
    endtask

    task automatic test_alias();
        logic [31:0] erd, d;
        logic eer;
        int elat;
        ref_op(1'b0, 2'd2, 1'b0, 32'h1010, 32'd0, erd, eer, elat);
        issue(1'b0, 2'd2, 1'b0, 32'h1010, 32'd0);
        tests++;
        if (last_rd !== ref_mem[4] || last_maddr !== 32'd4) begin
            fails++;
            $display("FAIL alias_load: rdata=%h addr=%0d, required %h/4", last_rd, last_maddr, ref_mem[4]);
        end
        d = $urandom;
        ref_op(1'b1, 2'd2, 1'b0, 32'hFFFF_F014, d, erd, eer, elat);
        issue(1'b1, 2'd2, 1'b0, 32'hFFFF_F014, d);
        tests++;
        if (mem[5] !== d || last_maddr !== 32'd5) begin
            fails++;
            $display("FAIL alias_store: mem5=%h addr=%0d, required %h/5", mem[5], last_maddr, d);
        end
    endtask

    task automatic test_reset_midstore();
        logic saw_wr;
        saw_wr = 1'b0;
        drive_req(1'b1, 2'd0, 1'b0, 32'h20, 32'h00000055);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (mem_write) begin
                saw_wr = 1'b1;
                break;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (saw_wr !== 1'b1 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: reached_rmw_wr=%b wr=%b rd=%b, required 1/0/0", saw_wr, mem_write, mem_read);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                fails++;
                $display("FAIL rst_after[%0d]: resp_valid=%b ready=%b, required 0/1", c, resp_valid, req_ready);
            end
        end
        tests++;
        if (mem[8] !== ref_mem[8]) begin
            fails++;
            $display("FAIL rst_nowrite: mem8=%h, required %h", mem[8], ref_mem[8]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_prefill();
        test_word();
        test_byte_rmw();
        test_load_ext();
        test_errors();
        test_random();
        test_back_to_back();
        test_alias();
        test_reset_midstore();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
